// File: rtl/qsys_pio_lcd_wr_engine.sv
// Avalon-MM LCD port: CPU writes are queued in a FIFO and replayed as timed 8080-style write cycles.
// Optional completion interrupt is enabled by defining LCD_PIO_IRQ_EN.
module qsys_pio_lcd_wr_engine #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int SETUP_RST  = 1,
  parameter int PULSE_RST  = 2,
  parameter int HOLD_RST   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              lcd_rs,
  output logic              lcd_cs_n,
  output logic              lcd_wr_n,
  output logic              irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   setup_r, pulse_r, hold_r;
  logic [DATA_W:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               overflow;
  logic               done_pend, irq_mask;

  logic wr, push_req, push, pop, full, empty, busy, status_wr, hold_end, done_set;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign push_req  = wr & ~address[1];
  assign status_wr = wr & (address == 2'd2);
  assign full      = (level == DEPTH_L);
  assign empty     = (level == '0);
  assign push      = push_req & ~full;
  assign pop       = (state == IDLE) & ~empty;
  assign busy      = (state != IDLE) | ~empty;
  assign hold_end  = (state == HOLD) && (cnt == '0);
  assign done_set  = hold_end & empty;
  assign unused_wd = &{1'b0, writedata};

  // Storage holds data only; occupancy is tracked by the reset-controlled pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {~address[0], writedata[DATA_W-1:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      setup_r  <= CNT_W'(SETUP_RST);
      pulse_r  <= CNT_W'(PULSE_RST);
      hold_r   <= CNT_W'(HOLD_RST);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop);
      if (push_req & full)
        overflow <= 1'b1;
      else if (status_wr & writedata[3])
        overflow <= 1'b0;
      if (wr && address == 2'd3) begin
        setup_r <= writedata[CNT_W-1:0];
        pulse_r <= writedata[8 +: CNT_W];
        hold_r  <= writedata[16 +: CNT_W];
      end
    end
  end

  // Each phase runs its loaded count down to zero, so a count of N lasts N+1 clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      out_port <= '0;
      lcd_rs   <= 1'b1;
      lcd_cs_n <= 1'b1;
      lcd_wr_n <= 1'b1;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          out_port <= mem[rd_ptr][DATA_W-1:0];
          lcd_rs   <= mem[rd_ptr][DATA_W];
          lcd_cs_n <= 1'b0;
          cnt      <= setup_r;
          state    <= SETUP;
        end
        SETUP: if (cnt == '0) begin
          lcd_wr_n <= 1'b0;
          cnt      <= pulse_r;
          state    <= PULSE;
        end else cnt <= cnt - 1'b1;
        PULSE: if (cnt == '0) begin
          lcd_wr_n <= 1'b1;
          cnt      <= hold_r;
          state    <= HOLD;
        end else cnt <= cnt - 1'b1;
        HOLD: if (cnt == '0) begin
          lcd_cs_n <= 1'b1;
          state    <= IDLE;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LCD_PIO_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_pend <= 1'b0;
      irq_mask  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (status_wr) irq_mask <= writedata[8];
      if (done_set)
        done_pend <= 1'b1;
      else if (status_wr & writedata[4])
        done_pend <= 1'b0;
      irq <= done_pend & irq_mask;
    end
  end
`else
  logic unused_done;
  assign unused_done = done_set;
  assign done_pend   = 1'b0;
  assign irq_mask    = 1'b0;
  assign irq         = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd0, 2'd1: readdata[DATA_W-1:0] = out_port;
      2'd2: begin
        readdata[0]          = busy;
        readdata[1]          = full;
        readdata[2]          = empty;
        readdata[3]          = overflow;
        readdata[4]          = done_pend;
        readdata[8]          = irq_mask;
        readdata[15 +: LVL_W] = level;
      end
      default: begin
        readdata[CNT_W-1:0]   = setup_r;
        readdata[8 +: CNT_W]  = pulse_r;
        readdata[16 +: CNT_W] = hold_r;
      end
    endcase
  end

endmodule

// File: tb/tb_qsys_pio_lcd_wr_engine.sv
// Bench for qsys_pio_lcd_wr_engine: queued expected LCD cycles checked by a pin-level monitor.
module tb_qsys_pio_lcd_wr_engine;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_port;
  logic              lcd_rs, lcd_cs_n, lcd_wr_n, irq;

  always #5 clk = ~clk;

  qsys_pio_lcd_wr_engine #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port),
    .lcd_rs(lcd_rs), .lcd_cs_n(lcd_cs_n), .lcd_wr_n(lcd_wr_n), .irq(irq)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic              rs;
    logic [DATA_W-1:0] d;
    int                cs_len;
    int                wr_off;
    int                wr_len;
  } xfer_t;

  xfer_t exp_q[$];
  int s_t = 1, p_t = 2, h_t = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic xfer_t mk(input logic rs, input logic [DATA_W-1:0] d);
    xfer_t x;
    x.rs = rs; x.d = d;
    x.cs_len = s_t + p_t + h_t + 3;
    x.wr_off = s_t + 2;
    x.wr_len = p_t + 1;
    return x;
  endfunction

  // Pin monitor: measures each chip-select window and scores it against the next expected cycle.
  initial begin : mon
    bit in_x;
    int cs_cnt, wr_off, wr_cnt;
    logic [DATA_W-1:0] d0;
    logic rs0;
    bit unstable;
    xfer_t e;
    in_x = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) in_x = 0;
      else if (!lcd_cs_n) begin
        if (!in_x) begin
          in_x = 1; cs_cnt = 0; wr_cnt = 0; wr_off = 0; d0 = out_port; rs0 = lcd_rs; unstable = 0;
        end
        cs_cnt++;
        if (out_port !== d0 || lcd_rs !== rs0) unstable = 1;
        if (!lcd_wr_n) begin
          if (wr_cnt == 0) wr_off = cs_cnt;
          wr_cnt++;
        end
      end else if (in_x) begin
        in_x = 0;
        if (exp_q.size() == 0) chk("unexpected_cycle", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("bus_data", 32'(d0), 32'(e.d));
          chk("bus_rs", 32'(rs0), 32'(e.rs));
          chk("cs_low_len", cs_cnt, e.cs_len);
          chk("wr_fall_pos", wr_off, e.wr_off);
          chk("wr_low_len", wr_cnt, e.wr_len);
          chk("bus_stable", 32'(unstable), 32'd0);
        end
      end
    end
  end

  task automatic av_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic set_timing(input int s, input int p, input int h);
    logic [31:0] r;
    av_wr(2'd3, {8'h00, 8'(h), 8'(p), 8'(s)});
    s_t = s; p_t = p; h_t = h;
    av_rd(2'd3, r);
    chk("timing_readback", r, {8'h00, 8'(h), 8'(p), 8'(s)});
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int n;
    n = 0;
    av_rd(2'd2, st);
    while (st[0] && n < 3000) begin
      @(posedge clk); #1;
      av_rd(2'd2, st);
      n++;
    end
    if (st[0]) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  // Back-to-back writes from an idle, empty engine. Pops occur at relative edges 1, 1+P, 1+2P...
  // with P = setup+pulse+hold+4; a write is dropped when the queue already holds DEPTH words.
  task automatic burst(input int n, input bit rnd, input int base);
    int P, acc, pops;
    bit ovf;
    logic rs;
    logic [DATA_W-1:0] d;
    logic [31:0] st;
    P = s_t + p_t + h_t + 4;
    acc = 0; ovf = 0;
    wait_idle();
    for (int i = 0; i < n; i++) begin
      pops = 0;
      for (int k = 0; 1 + k * P < i; k++) pops++;
      if (pops > acc) pops = acc;
      rs = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      d  = rnd ? DATA_W'($urandom()) : DATA_W'(base + i);
      if (acc - pops == DEPTH) ovf = 1;
      else begin
        acc++;
        exp_q.push_back(mk(rs, d));
      end
      av_wr(rs ? 2'd0 : 2'd1, {$urandom(), 16'h0} | 32'(d));
    end
    av_rd(2'd2, st);
    chk("overflow_flag", 32'(st[3]), 32'(ovf));
    wait_idle();
    av_wr(2'd2, 32'h0000_0008);
    av_rd(2'd2, st);
    chk("overflow_w1c", 32'(st[3]), 32'd0);
  endtask

  initial begin : stim
    logic [31:0] r;
    int cnt;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("rst_rs", 32'(lcd_rs), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    av_rd(2'd2, r);
    chk("rst_status", r, 32'h0000_0004);
    av_rd(2'd3, r);
    chk("rst_timing", r, 32'h0001_0201);

    set_timing(1, 2, 1);
    exp_q.push_back(mk(1'b1, 16'hABCD));
    av_wr(2'd0, 32'h5555_ABCD);
    wait_idle();
    av_rd(2'd0, r);
    chk("data_readback", r, 32'h0000_ABCD);
    exp_q.push_back(mk(1'b0, 16'h002C));
    av_wr(2'd1, 32'h0000_002C);
    av_rd(2'd2, r);
    chk("busy_during_cycle", 32'(r[0]), 32'd1);
    wait_idle();
    av_rd(2'd1, r);
    chk("cmd_readback", r, 32'h0000_002C);
    av_rd(2'd2, r);
    chk("status_idle_low", {r[31:15] , r[3:0]}, 32'h4);

    burst(10, 1'b0, 0);

    for (int it = 0; it < 12; it++) begin
      set_timing($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      burst($urandom_range(1, 10), 1'b1, 0);
    end

`ifdef LCD_PIO_IRQ_EN
    set_timing(1, 2, 1);
    av_wr(2'd2, 32'h0000_0110);
    @(posedge clk); #1;
    chk("irq_cleared_pre", 32'(irq), 32'd0);
    exp_q.push_back(mk(1'b1, 16'h1111));
    exp_q.push_back(mk(1'b1, 16'h2222));
    av_wr(2'd0, 32'h1111);
    av_wr(2'd0, 32'h2222);
    wait_idle();
    @(posedge clk); #1;
    chk("irq_after_done", 32'(irq), 32'd1);
    av_rd(2'd2, r);
    chk("done_pend_set", 32'(r[4]), 32'd1);
    av_wr(2'd2, 32'h0000_0110);
    @(posedge clk); #1;
    chk("irq_after_w1c", 32'(irq), 32'd0);
`else
    chk("irq_tied_low", 32'(irq), 32'd0);
    av_rd(2'd2, r);
    chk("no_done_mask_bits", {r[8], r[4]}, 32'd0);
`endif

    // Abort a transfer in its strobe phase with a second word still queued.
    set_timing(2, 20, 2);
    wait_idle();
    av_wr(2'd0, 32'h5A5A);
    av_wr(2'd1, 32'h1234);
    cnt = 0;
    while (lcd_wr_n && cnt < 200) begin @(posedge clk); #1; cnt++; end
    chk("reached_pulse", 32'(lcd_wr_n), 32'd0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("abort_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("abort_out_port", 32'(out_port), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    s_t = 1; p_t = 2; h_t = 1;
    av_rd(2'd2, r);
    chk("abort_status", r, 32'h0000_0004);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (!lcd_cs_n) cnt++; end
    chk("abort_no_cycle", cnt, 0);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin @(posedge clk); cnt++; end
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
